// File: rtl/pcie_reg_initiator.sv
// pcie_reg_initiator
// Turns single register commands (read or write) into ioport2 request
// messages, collects the matching response, and hands back one completion
// per command. Only one transaction is outstanding at a time. A watchdog
// aborts a transaction that does not finish within TIMEOUT_CYCLES bus cycles.
// Responses that arrive when no read is waiting are counted and dropped.
//
// ioport2 message layout (64 bits):
//   [63]    wr_request
//   [62]    rd_request
//   [61:52] reserved, zero
//   [51:32] register address
//   [31:0]  data (write payload on requests, read value on responses)
//
// Every output is driven straight from a flop. Output flops are loaded with
// the value implied by the next state, so each output matches the current
// state in the same cycle.

module pcie_reg_initiator #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_tvalid,
    output logic        cmd_tready,
    input  logic        cmd_wr,
    input  logic [19:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic [63:0] regi_tdata,
    output logic        regi_tvalid,
    input  logic        regi_tready,
    input  logic [63:0] rego_tdata,
    input  logic        rego_tvalid,
    output logic        rego_tready,
    output logic        resp_tvalid,
    input  logic        resp_tready,
    output logic [31:0] resp_data,
    output logic        resp_timeout,
    output logic        busy,
    output logic [7:0]  stray_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] TIMER_LAST = TIMEOUT_CYCLES - 32'd1;
    localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;

    // Build an ioport2 request message.
    function automatic logic [63:0] ioport2_msg_encode(
        input logic        wr_request,
        input logic        rd_request,
        input logic [19:0] address,
        input logic [31:0] data
    );
        logic [63:0] msg;
        msg          = 64'd0;
        msg[63]      = wr_request;
        msg[62]      = rd_request;
        msg[51:32]   = address;
        msg[31:0]    = data;
        return msg;
    endfunction

    // Extract the 32-bit payload from an ioport2 response message.
    function automatic logic [31:0] ioport2_msg_decode(
        input logic [63:0] msg
    );
        return msg[31:0];
    endfunction

    // State and latched command
    state_t      state_r;
    logic        wr_r;
    logic        req_done_r;
    logic        resp_done_r;
    logic [31:0] timer_r;

    // Next-state values
    state_t      state_nx_s;
    logic        wr_nx_s;
    logic        req_done_nx_s;
    logic        resp_done_nx_s;
    logic        complete_s;
    logic        timeout_s;

    // Next values of the registered control outputs
    logic        cmd_tready_nx_s;
    logic        regi_tvalid_nx_s;
    logic        rego_tready_nx_s;
    logic        resp_tvalid_nx_s;
    logic        busy_nx_s;

    // Handshakes seen this cycle
    logic        cmd_fire_s;
    logic        req_fire_s;
    logic        rego_fire_s;
    logic        resp_fire_s;
    logic        stray_hit_s;

    assign cmd_fire_s  = cmd_tvalid  & cmd_tready;
    assign req_fire_s  = regi_tvalid & regi_tready;
    assign rego_fire_s = rego_tvalid & rego_tready;
    assign resp_fire_s = resp_tvalid & resp_tready;

    // A response is stray unless a read is in REQ still waiting for its data.
    assign stray_hit_s = rego_fire_s & ((state_r != ST_REQ) | wr_r | resp_done_r);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic, including the progress flags that decide completion.
    always_comb begin
        state_nx_s     = state_r;
        wr_nx_s        = wr_r;
        req_done_nx_s  = req_done_r;
        resp_done_nx_s = resp_done_r;
        complete_s     = 1'b0;
        timeout_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    state_nx_s     = ST_REQ;
                    wr_nx_s        = cmd_wr;
                    req_done_nx_s  = 1'b0;
                    resp_done_nx_s = 1'b0;
                end else begin
                    state_nx_s     = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Request and response handshakes may land in the same cycle.
                req_done_nx_s  = req_done_r | req_fire_s;
                resp_done_nx_s = resp_done_r | (rego_fire_s & ~wr_r);
                complete_s     = req_done_nx_s & (wr_r | resp_done_nx_s);
                if (complete_s) begin
                    state_nx_s = ST_DONE;
                end else if (timer_r == TIMER_LAST) begin
                    state_nx_s = ST_DONE;
                    timeout_s  = 1'b1;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_DONE: begin
                if (resp_fire_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, ready to be registered.
    always_comb begin
        cmd_tready_nx_s  = 1'b0;
        regi_tvalid_nx_s = 1'b0;
        rego_tready_nx_s = 1'b1;
        resp_tvalid_nx_s = 1'b0;
        busy_nx_s        = 1'b1;
        case (state_nx_s)
            ST_IDLE: begin
                cmd_tready_nx_s  = 1'b1;
                busy_nx_s        = 1'b0;
            end
            ST_REQ: begin
                regi_tvalid_nx_s = ~req_done_nx_s;
                // A read stops accepting once its data is in; writes never do.
                rego_tready_nx_s = wr_nx_s | ~resp_done_nx_s;
            end
            ST_DONE: begin
                resp_tvalid_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s        = 1'b0;
            end
        endcase
    end

    // Registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_tready  <= 1'b1;
            regi_tvalid <= 1'b0;
            rego_tready <= 1'b1;
            resp_tvalid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cmd_tready  <= cmd_tready_nx_s;
            regi_tvalid <= regi_tvalid_nx_s;
            rego_tready <= rego_tready_nx_s;
            resp_tvalid <= resp_tvalid_nx_s;
            busy        <= busy_nx_s;
        end
    end

    // Command latch, progress flags, watchdog timer and completion payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_r         <= 1'b0;
            req_done_r   <= 1'b0;
            resp_done_r  <= 1'b0;
            timer_r      <= 32'd0;
            regi_tdata   <= 64'd0;
            resp_data    <= 32'd0;
            resp_timeout <= 1'b0;
        end else begin
            wr_r        <= wr_nx_s;
            req_done_r  <= req_done_nx_s;
            resp_done_r <= resp_done_nx_s;
            if (state_r == ST_IDLE) begin
                if (cmd_fire_s) begin
                    // Read requests carry a zero data field.
                    regi_tdata   <= ioport2_msg_encode(cmd_wr, ~cmd_wr, cmd_addr,
                                                       cmd_wr ? cmd_data : 32'd0);
                    timer_r      <= 32'd0;
                    resp_data    <= 32'd0;
                    resp_timeout <= 1'b0;
                end else begin
                    timer_r      <= timer_r;
                end
            end else if (state_r == ST_REQ) begin
                timer_r <= timer_r + 32'd1;
                if (timeout_s) begin
                    resp_data    <= ABORT_DATA;
                    resp_timeout <= 1'b1;
                end else if (rego_fire_s && !wr_r && !resp_done_r) begin
                    resp_data    <= ioport2_msg_decode(rego_tdata);
                end else begin
                    resp_data    <= resp_data;
                end
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Saturating count of responses nobody was waiting for.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stray_count <= 8'd0;
        end else begin
            if (stray_hit_s && (stray_count != 8'hFF)) begin
                stray_count <= stray_count + 8'd1;
            end else begin
                stray_count <= stray_count;
            end
        end
    end

endmodule

// File: tb/tb_pcie_reg_initiator.sv
// Directed bench for pcie_reg_initiator with hand-computed expectations.
// Request layout: {wr, rd, 10'b0, addr[19:0], data[31:0]}.

module tb_pcie_reg_initiator;

    logic        clk;
    logic        reset;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic        cmd_wr;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [63:0] regi_tdata;
    logic        regi_tvalid;
    logic        regi_tready;
    logic [63:0] rego_tdata;
    logic        rego_tvalid;
    logic        rego_tvalid_drv;
    logic        comb_mode;
    logic        rego_tready;
    logic        resp_tvalid;
    logic        resp_tready;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        busy;
    logic [7:0]  stray_count;

    int n_checks;
    int n_fail;

    // In comb_mode the responder answers in the same cycle the request is taken.
    assign rego_tvalid = comb_mode ? (regi_tvalid & regi_tready) : rego_tvalid_drv;

    pcie_reg_initiator #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_tvalid   (cmd_tvalid),
        .cmd_tready   (cmd_tready),
        .cmd_wr       (cmd_wr),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .regi_tdata   (regi_tdata),
        .regi_tvalid  (regi_tvalid),
        .regi_tready  (regi_tready),
        .rego_tdata   (rego_tdata),
        .rego_tvalid  (rego_tvalid),
        .rego_tready  (rego_tready),
        .resp_tvalid  (resp_tvalid),
        .resp_tready  (resp_tready),
        .resp_data    (resp_data),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .stray_count  (stray_count)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_cmd(input logic wr, input logic [19:0] addr, input logic [31:0] data);
        cmd_tvalid = 1'b1;
        cmd_wr     = wr;
        cmd_addr   = addr;
        cmd_data   = data;
    endtask

    // Directed sequence.
    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        cmd_tvalid      = 1'b0;
        cmd_wr          = 1'b0;
        cmd_addr        = 20'd0;
        cmd_data        = 32'd0;
        regi_tready     = 1'b0;
        rego_tdata      = 64'd0;
        rego_tvalid_drv = 1'b0;
        comb_mode       = 1'b0;
        resp_tready     = 1'b0;
        #1;
        chk("rst_regi_tvalid", 64'(regi_tvalid), 64'd0);
        chk("rst_resp_tvalid", 64'(resp_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stray", 64'(stray_count), 64'd0);
        chk("rst_regi_tdata", regi_tdata, 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_timeout", 64'(resp_timeout), 64'd0);
        step();
        step();
        reset = 1'b0;
        chk("idle_cmd_tready", 64'(cmd_tready), 64'd1);

        // Write 0xDEADBEEF to 0x00010, responder always ready.
        regi_tready = 1'b1;
        offer_cmd(1'b1, 20'h00010, 32'hDEADBEEF);
        step();
        cmd_tvalid = 1'b0;
        chk("wr_busy", 64'(busy), 64'd1);
        chk("wr_cmd_tready", 64'(cmd_tready), 64'd0);
        chk("wr_regi_tvalid", 64'(regi_tvalid), 64'd1);
        chk("wr_regi_tdata", regi_tdata, 64'h80000010_DEADBEEF);
        step();
        chk("wr_single_beat", 64'(regi_tvalid), 64'd0);
        chk("wr_resp_tvalid", 64'(resp_tvalid), 64'd1);
        chk("wr_resp_data", 64'(resp_data), 64'd0);
        chk("wr_resp_timeout", 64'(resp_timeout), 64'd0);
        resp_tready = 1'b1;
        step();
        resp_tready = 1'b0;
        regi_tready = 1'b0;
        chk("wr_back_idle", 64'(cmd_tready), 64'd1);
        chk("wr_resp_tvalid_low", 64'(resp_tvalid), 64'd0);

        // Read 0x00000 against a same-cycle responder.
        comb_mode   = 1'b1;
        rego_tdata  = 64'h00000000_12345678;
        regi_tready = 1'b1;
        offer_cmd(1'b0, 20'h00000, 32'h55555555);
        step();
        cmd_tvalid = 1'b0;
        chk("rd0_regi_tdata", regi_tdata, 64'h40000000_00000000);
        chk("rd0_rego_tready", 64'(rego_tready), 64'd1);
        step();
        chk("rd0_resp_tvalid", 64'(resp_tvalid), 64'd1);
        chk("rd0_resp_data", 64'(resp_data), 64'h12345678);
        chk("rd0_resp_timeout", 64'(resp_timeout), 64'd0);
        resp_tready = 1'b1;
        step();
        resp_tready = 1'b0;
        comb_mode   = 1'b0;
        regi_tready = 1'b0;
        chk("rd0_stray", 64'(stray_count), 64'd0);
        chk("rd0_idle", 64'(busy), 64'd0);

        // Read 0x00ABC, response 5 cycles after the request, slow consumer.
        offer_cmd(1'b0, 20'h00ABC, 32'd0);
        step();
        cmd_tvalid  = 1'b0;
        regi_tready = 1'b1;
        chk("rd1_regi_tdata", regi_tdata, 64'h40000ABC_00000000);
        step();
        regi_tready = 1'b0;
        chk("rd1_req_dropped", 64'(regi_tvalid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rd1_wait_resp", 64'(resp_tvalid), 64'd0);
            step();
        end
        chk("rd1_rego_tready", 64'(rego_tready), 64'd1);
        rego_tvalid_drv = 1'b1;
        rego_tdata      = 64'h00000000_CAFEF00D;
        step();
        rego_tvalid_drv = 1'b0;
        rego_tdata      = 64'h00000000_0BAD0BAD;
        chk("rd1_resp_tvalid", 64'(resp_tvalid), 64'd1);
        chk("rd1_resp_data", 64'(resp_data), 64'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd1_hold_valid", 64'(resp_tvalid), 64'd1);
            chk("rd1_hold_data", 64'(resp_data), 64'hCAFEF00D);
        end
        resp_tready = 1'b1;
        step();
        resp_tready = 1'b0;
        chk("rd1_idle", 64'(cmd_tready), 64'd1);
        chk("rd1_stray", 64'(stray_count), 64'd0);

        // Timeout: nobody ever takes the request (TIMEOUT_CYCLES = 16).
        offer_cmd(1'b1, 20'h00005, 32'h00000001);
        step();
        cmd_tvalid = 1'b0;
        chk("to_regi_tvalid_0", 64'(regi_tvalid), 64'd1);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("to_regi_tvalid_held", 64'(regi_tvalid), 64'd1);
        end
        step();
        chk("to_regi_tvalid_drop", 64'(regi_tvalid), 64'd0);
        chk("to_resp_tvalid", 64'(resp_tvalid), 64'd1);
        chk("to_resp_timeout", 64'(resp_timeout), 64'd1);
        chk("to_resp_data", 64'(resp_data), 64'hFFFFFFFF);
        resp_tready = 1'b1;
        step();
        resp_tready = 1'b0;
        chk("to_idle", 64'(busy), 64'd0);

        // 300 unsolicited responses while idle.
        rego_tvalid_drv = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 1) chk("stray_first", 64'(stray_count), 64'd1);
            if (i == 254) chk("stray_254", 64'(stray_count), 64'hFE);
        end
        rego_tvalid_drv = 1'b0;
        chk("stray_sat", 64'(stray_count), 64'hFF);
        chk("stray_no_resp", 64'(resp_tvalid), 64'd0);

        // Reset in the middle of a pending read request.
        offer_cmd(1'b0, 20'h12345, 32'd0);
        step();
        cmd_tvalid = 1'b0;
        chk("mid_regi_tvalid", 64'(regi_tvalid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_regi_tvalid", 64'(regi_tvalid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_stray", 64'(stray_count), 64'd0);
        step();
        reset = 1'b0;
        chk("mid_rst_no_resp", 64'(resp_tvalid), 64'd0);

        // First read after reset completes normally.
        comb_mode   = 1'b1;
        rego_tdata  = 64'h00000000_0BADF00D;
        regi_tready = 1'b1;
        offer_cmd(1'b0, 20'h00004, 32'd0);
        step();
        cmd_tvalid = 1'b0;
        chk("post_regi_tdata", regi_tdata, 64'h40000004_00000000);
        step();
        chk("post_resp_data", 64'(resp_data), 64'h0BADF00D);
        chk("post_resp_timeout", 64'(resp_timeout), 64'd0);
        resp_tready = 1'b1;
        step();
        resp_tready = 1'b0;
        comb_mode   = 1'b0;
        regi_tready = 1'b0;
        chk("post_stray", 64'(stray_count), 64'd0);

        // Response arriving during a write is stray.
        offer_cmd(1'b1, 20'h00020, 32'h00000077);
        step();
        cmd_tvalid      = 1'b0;
        chk("wrs_rego_tready", 64'(rego_tready), 64'd1);
        rego_tvalid_drv = 1'b1;
        step();
        rego_tvalid_drv = 1'b0;
        chk("wrs_stray", 64'(stray_count), 64'd1);
        chk("wrs_regi_tvalid", 64'(regi_tvalid), 64'd1);
        regi_tready = 1'b1;
        step();
        regi_tready = 1'b0;
        chk("wrs_resp_data", 64'(resp_data), 64'd0);
        resp_tready = 1'b1;
        step();
        resp_tready = 1'b0;
        chk("wrs_idle", 64'(cmd_tready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_reg_initiator.md
PCIE_REG_INITIATOR -- requirements
Module: pcie_reg_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd1024: bus cycles allowed per transaction before abort.
REQ-002 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_tvalid  input  1: command offered.
REQ-005 SHALL have port cmd_tready  output  1: command accepted.
REQ-006 SHALL have port cmd_wr  input  1: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  20: register address.
REQ-008 SHALL have port cmd_data  input  32: write payload; ignored for reads.
REQ-009 SHALL have port regi_tdata  output  64: request message, built by ioport2_msg_encode (wr_request, rd_request, address, data).
REQ-010 SHALL have port regi_tvalid  output  1: request message valid.
REQ-011 SHALL have port regi_tready  input  1: request message consumed.
REQ-012 SHALL have port rego_tdata  input  64: response message, parsed by ioport2_msg_decode; payload data is the 32-bit read value.
REQ-013 SHALL have port rego_tvalid  input  1: response valid.
REQ-014 SHALL have port rego_tready  output  1: response accepted.
REQ-015 SHALL have port resp_tvalid  output  1: completion available.
REQ-016 SHALL have port resp_tready  input  1: completion consumed.
REQ-017 SHALL have port resp_data  output  32: read data; 0 for writes; 32'hFFFFFFFF on timeout.
REQ-018 SHALL have port resp_timeout  output  1: completion was aborted by timeout.
REQ-019 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-020 SHALL have port stray_count  output  8: responses received with no read outstanding; saturates at 8'hFF.

Function
REQ-021 SHALL implement states IDLE, REQ, DONE; one transaction outstanding at a time.
REQ-022 IDLE: cmd_tready=1; on cmd_tvalid, latch wr/addr/data, clear flags req_done/resp_done, clear timer, go to REQ next cycle.
REQ-023 REQ: regi_tvalid=1 while req_done=0; regi_tdata held stable from latched command until regi_tvalid&regi_tready.
REQ-024 REQ read: rego_tready=1 while resp_done=0; on rego_tvalid&rego_tready latch payload into resp_data and set resp_done.
REQ-025 Request acceptance and response acceptance SHALL be independent: both in the same cycle is legal (combinational responder), as is response any later cycle.
REQ-026 Write completes when req_done set; read completes when req_done and resp_done are both set; completion moves to DONE next cycle.
REQ-027 Timer SHALL increment each REQ cycle; when it reaches TIMEOUT_CYCLES-1 with the transaction incomplete: drop regi_tvalid, set resp_timeout=1, resp_data=32'hFFFFFFFF, go to DONE.
REQ-028 DONE: resp_tvalid=1 with resp_data/resp_timeout stable until resp_tready; then go to IDLE (cmd_tready high the next cycle, minimum 3 cycles per command).
REQ-029 rego_tready SHALL be 1 in IDLE and DONE; any response accepted there increments stray_count (saturating) and is discarded.
REQ-030 Write path: rego_tready in REQ SHALL still be 1 and any response then is counted as stray.
REQ-031 cmd_tready SHALL be 0 outside IDLE; resp_tvalid SHALL be 0 outside DONE.

Reset
REQ-032 On reset assertion, asynchronously: state=IDLE, regi_tvalid=0, resp_tvalid=0, resp_timeout=0, resp_data=0, stray_count=0, regi_tdata=0, busy=0, timer=0.
REQ-033 Reset mid-transaction SHALL abandon it without a completion; first command after release proceeds normally.

Verification
REQ-034 Write addr 20'h00010 data 32'hDEADBEEF, responder tready 1 -> one request beat with wr_request, completion resp_data=0, resp_timeout=0.
REQ-035 Read addr 20'h00000 against combinational responder returning 32'h12345678 same cycle as regi_tready -> resp_data=32'h12345678, no stray.
REQ-036 Read with response 5 cycles after regi_tready, resp_tready held low 3 cycles -> resp_tvalid/resp_data stable for those cycles, then IDLE.
REQ-037 TIMEOUT_CYCLES=16, regi_tready never asserted -> regi_tvalid falls after 16 REQ cycles, resp_timeout=1, resp_data=32'hFFFFFFFF.
REQ-038 300 unsolicited responses while IDLE -> stray_count=8'hFF, no resp_tvalid.
REQ-039 Reset asserted during REQ with regi_tvalid high -> regi_tvalid low immediately (same cycle, no clock edge), busy=0, next read completes correctly.
